// File: rtl/jt10_adpcm_pkg.sv
// Shared types and defaults for the ADPCM burst scheduler and its arbiters.
package jt10_adpcm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_BURST,
    ST_DONE
  } sched_state_t;

  localparam int unsigned NCH_A     = 6;
  localparam int unsigned BURST_DEF = 6;

endpackage

// File: rtl/jt10_rr_pick.sv
// Combinational round-robin picker: first set request searching upward from
// last+1 with wrap, so the previous winner has the lowest priority.
module jt10_rr_pick #(
  parameter int unsigned NCH = 6,
  parameter int unsigned IDW = 3
) (
  input  logic [NCH-1:0] req,
  input  logic [IDW-1:0] last,
  output logic           any,
  output logic [NCH-1:0] onehot,
  output logic [IDW-1:0] id
);

  logic [IDW-1:0] w_idx;

  // Scan from lowest to highest priority so the highest-priority hit is the
  // last assignment to stick.
  always_comb begin
    any    = 1'b0;
    onehot = '0;
    id     = '0;
    w_idx  = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      w_idx = IDW'((32'(last) + NCH - k) % NCH);
      if (req[w_idx]) begin
        any         = 1'b1;
        onehot      = '0;
        onehot[w_idx] = 1'b1;
        id          = w_idx;
      end
    end
  end

endmodule

// File: rtl/jt10_burst_sched.sv
// Round-robin owner of the shared cen burst slot: start strobe, BURST gated
// cen pulses, then a done strobe per grant.
module jt10_burst_sched
  import jt10_adpcm_pkg::*;
#(
  parameter int unsigned NCH   = NCH_A,
  parameter int unsigned BURST = BURST_DEF,
  parameter int unsigned CNTW  = 3,
  parameter int unsigned IDW   = 3
) (
  input  logic           rst_n,
  input  logic           clk,
  input  logic           cen,
  input  logic [NCH-1:0] req,
  output logic           start,
  output logic           cen_out,
  output logic [NCH-1:0] grant,
  output logic [IDW-1:0] gnt_id,
  output logic           busy,
  output logic           done
);

  sched_state_t   r_state;
  logic           r_start;
  logic           r_gate;
  logic           r_done;
  logic [NCH-1:0] r_grant;
  logic [IDW-1:0] r_gnt_id;
  logic [CNTW-1:0] r_cnt;
  logic [IDW-1:0] r_last;

  logic           w_any;
  logic [NCH-1:0] w_onehot;
  logic [IDW-1:0] w_id;

  jt10_rr_pick #(
    .NCH (NCH),
    .IDW (IDW)
  ) u_pick (
    .req    (req),
    .last   (r_last),
    .any    (w_any),
    .onehot (w_onehot),
    .id     (w_id)
  );

  // DONE arbitrates like IDLE so back-to-back grants are BURST+2 cen apart.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_start  <= 1'b0;
      r_gate   <= 1'b0;
      r_done   <= 1'b0;
      r_grant  <= '0;
      r_gnt_id <= '0;
      r_cnt    <= '0;
      r_last   <= IDW'(NCH - 1);
    end else if (cen) begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          r_done <= 1'b0;
          if (w_any) begin
            r_grant  <= w_onehot;
            r_gnt_id <= w_id;
            r_last   <= w_id;
            r_start  <= 1'b1;
            r_state  <= ST_START;
          end else begin
            r_grant  <= '0;
            r_gnt_id <= '0;
            r_state  <= ST_IDLE;
          end
        end
        ST_START: begin
          r_start <= 1'b0;
          r_gate  <= 1'b1;
          r_cnt   <= '0;
          r_state <= ST_BURST;
        end
        ST_BURST: begin
          if (r_cnt == CNTW'(BURST - 1)) begin
            r_gate  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign start   = r_start;
  assign done    = r_done;
  assign grant   = r_grant;
  assign gnt_id  = r_gnt_id;
  assign busy    = (r_state != ST_IDLE);
  assign cen_out = cen & r_gate;

endmodule

// File: tb/tb_jt10_burst_sched.sv
// Scoreboard bench for jt10_burst_sched: stimulus queues expected grants,
// a monitor samples once per cen period and checks owner, spacing and pulses.
module tb_jt10_burst_sched;

  localparam int NCH   = 6;
  localparam int BURST = 6;

  logic           clk   = 1'b0;
  logic           rst_n = 1'b0;
  logic           cen   = 1'b0;
  logic [NCH-1:0] req   = '0;
  logic           start, cen_out, busy, done;
  logic [NCH-1:0] grant;
  logic [2:0]     gnt_id;

  jt10_burst_sched #(
    .NCH   (NCH),
    .BURST (BURST),
    .CNTW  (3),
    .IDW   (3)
  ) dut (
    .rst_n   (rst_n),
    .clk     (clk),
    .cen     (cen),
    .req     (req),
    .start   (start),
    .cen_out (cen_out),
    .grant   (grant),
    .gnt_id  (gnt_id),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int id;
    int gap;
  } exp_t;

  exp_t q[$];
  int checks = 0, errors = 0;
  int n_starts = 0, n_dones = 0, pulses = 0, pc = 0, last_pc = 0, cur_id = 0;
  int inv_viol = 0, frz_viol = 0;
  bit rnd_mode = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // cen: every 4th clk, or random with long idle runs
  initial begin
    int unsigned phase = 0;
    int unsigned zrun  = 0;
    forever begin
      @(negedge clk);
      if (!rnd_mode) begin
        phase = (phase + 1) % 4;
        cen   = (phase == 0);
      end else if (zrun > 0) begin
        zrun--;
        cen = 1'b0;
      end else if ($urandom_range(0, 15) == 0) begin
        zrun = $urandom_range(20, 60);
        cen  = 1'b0;
      end else begin
        cen = ($urandom_range(0, 2) == 0);
      end
    end
  end

  // Monitor: each cen-high sample sees the state held during the period
  // that ends at the coming cen edge.
  initial begin
    logic [11:0] prev_snap = '0;
    bit          prev_cen  = 1'b0;
    bit          have_prev = 1'b0;
    exp_t        e;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        have_prev = 1'b0;
        pulses    = 0;
      end else begin
        if (cen_out && !cen) inv_viol++;
        if (have_prev && !prev_cen && ({grant, gnt_id, start, done, busy} !== prev_snap))
          frz_viol++;
        prev_snap = {grant, gnt_id, start, done, busy};
        prev_cen  = cen;
        have_prev = 1'b1;
        if (cen) begin
          pc++;
          if (start) begin
            if (q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL grant_expected: got grant id %0d expected no grant", gnt_id);
            end else begin
              e = q.pop_front();
              check("grant_onehot", grant, 32'(1 << e.id));
              check("gnt_id", gnt_id, e.id);
              check("busy_on_start", busy, 1);
              if (e.gap > 0) check("grant_spacing", pc - last_pc, e.gap);
            end
            cur_id  = gnt_id;
            last_pc = pc;
            pulses  = 0;
            n_starts++;
          end
          if (cen_out) pulses++;
          if (done) begin
            check("pulses_per_grant", pulses, BURST);
            check("done_owner", gnt_id, cur_id);
            n_dones++;
          end
        end
      end
    end
  end

  task automatic expect_grant(input int id, input int gap);
    exp_t e;
    e.id  = id;
    e.gap = gap;
    q.push_back(e);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #3 check("reset_outs", {start, cen_out, grant, gnt_id, busy, done}, 0);
    @(negedge clk);
    n_starts = 0;
    n_dones  = 0;
    rst_n    = 1'b1;
  endtask

  task automatic wait_starts(input int n, input int budget, input string name);
    int t = 0;
    while (n_starts < n && t < budget) begin
      @(negedge clk);
      t++;
    end
    check(name, n_starts >= n, 1);
  endtask

  task automatic wait_idle(input int budget, input string name);
    int t = 0;
    while (busy !== 1'b0 && t < budget) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    @(negedge clk);
    check(name, busy, 0);
  endtask

  initial begin
    int t;
    // single requester held: regranted after done
    do_reset();
    expect_grant(0, 0);
    expect_grant(0, 8);
    req = 6'b000001;
    wait_starts(2, 2000, "t1_starts");
    req = '0;
    wait_idle(2000, "t1_idle");
    check("t1_dones", n_dones, 2);

    // all requesting: rotation 0..5,0
    do_reset();
    expect_grant(0, 0);
    for (int i = 1; i < 6; i++) expect_grant(i, 8);
    expect_grant(0, 8);
    req = 6'b111111;
    wait_starts(7, 3000, "t2_starts");
    req = '0;
    wait_idle(2000, "t2_idle");
    check("t2_dones", n_dones, 7);

    // 0 wins from last=5, then 5 follows with no gap
    do_reset();
    expect_grant(0, 0);
    expect_grant(5, 8);
    req = 6'b100001;
    wait_starts(1, 2000, "t3_first");
    req = 6'b100000;
    wait_starts(2, 2000, "t3_second");
    req = '0;
    wait_idle(2000, "t3_idle");
    check("t3_dones", n_dones, 2);

    // owner drops request mid-burst
    do_reset();
    expect_grant(0, 0);
    expect_grant(1, 8);
    req = 6'b000011;
    wait_starts(1, 2000, "t4_first");
    req = 6'b000010;
    wait_starts(2, 2000, "t4_second");
    req = '0;
    wait_idle(2000, "t4_idle");
    check("t4_dones", n_dones, 2);

    // reset during burst after the 3rd pulse
    do_reset();
    expect_grant(0, 0);
    req = 6'b000001;
    wait_starts(1, 2000, "t5_start");
    t = 0;
    while (pulses < 3 && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("t5_three_pulses", pulses >= 3, 1);
    t = 0;
    do begin
      @(negedge clk);
      #2;
      t++;
    end while (!(cen && cen_out) && t < 500);
    check("t5_pulse_pending", cen_out, 1);
    rst_n = 1'b0;
    #1 check("t5_reset_kill", {cen_out, grant, busy}, 0);
    req = 6'b111111;
    repeat (3) @(negedge clk);
    n_starts = 0;
    n_dones  = 0;
    expect_grant(0, 0);
    rst_n = 1'b1;
    wait_starts(1, 2000, "t5_regrant");
    req = '0;
    wait_idle(2000, "t5_idle");
    check("t5_dones", n_dones, 1);

    // random cen gaps
    rnd_mode = 1'b1;
    do_reset();
    expect_grant(0, 0);
    expect_grant(1, 8);
    expect_grant(2, 8);
    req = 6'b111111;
    wait_starts(3, 20000, "t6_starts");
    req = '0;
    wait_idle(20000, "t6_idle");
    check("t6_dones", n_dones, 3);

    check("queue_empty", q.size(), 0);
    check("cen_out_without_cen", inv_viol, 0);
    check("frozen_without_cen", frz_viol, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
